mem_access_unit: RTL and testbench

Sequential data-memory access unit for the RV32 core. Sits between the execute stage and the 32-bit word-wide data bus. Turns one load/store request (byte, half or word at any byte address) into bus transactions: a single read for loads, read-modify-write for sub-word stores, and a single write for word stores. Uses the existing combinational load/store alignment helper for extraction, sign-extension and merging.

---
 rtl/mem_access_if.sv | 34 +++
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Request/response and data-bus signal bundle for mem_access_unit.
// The slave modport is the access unit itself; master is the core/bus side.
interface mem_access_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [1:0]  reqLen;
    logic        reqSignExtend;
    logic [31:0] reqWData;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rspError;
    logic [31:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqLen, reqSignExtend, reqWData,
        input  memRData, memAck,
        output reqReady, rspValid, rspData, rspError,
        output memAddr, memRead, memWrite, memWData
    );

    modport master (
        output reqValid, reqWrite, reqAddr, reqLen, reqSignExtend, reqWData,
        output memRData, memAck,
        input  reqReady, rspValid, rspData, rspError,
        input  memAddr, memRead, memWrite, memWData
    );
endinterface

// File: rtl/mem_access_unit.sv
// Sequential RV32 data-memory access unit: one load/store request becomes a
// single read, a single write, or a read-modify-write on the word-wide bus.
module mem_access_unit #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    mem_access_if.slave bus
);
    localparam logic [1:0]  LOAD_STORE_BYTE = 2'b00;
    localparam logic [1:0]  LOAD_STORE_HALF = 2'b01;
    localparam logic [15:0] CNT_LAST        = 16'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  off;
    logic [1:0]  len;
    logic        is_write;
    logic        sext;
    logic [31:0] wdata;
    logic [15:0] cnt;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic [1:0]  req_off;
    logic        req_word;
    logic        req_misaligned;
    logic        accept;
    logic        timeout;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  offset,
                                                 input logic [1:0]  size,
                                                 input logic        sign_ext);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (size)
            LOAD_STORE_BYTE: load_extract = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            LOAD_STORE_HALF: load_extract = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default:         load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  offset,
                                                input logic [1:0]  size);
        logic [31:0] mask;
        mask = (size == LOAD_STORE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
        store_merge = (word & ~(mask << {offset, 3'b000}))
                    | ((data & mask) << {offset, 3'b000});
    endfunction

    assign req_off        = bus.reqAddr[1:0];
    assign req_word       = (bus.reqLen != LOAD_STORE_BYTE) && (bus.reqLen != LOAD_STORE_HALF);
    // A half at offset 1 stays inside one word; only offset 3 crosses the boundary.
    assign req_misaligned = (bus.reqLen == LOAD_STORE_HALF) ? (req_off == 2'd3)
                                                            : (req_word && (req_off != 2'd0));
    assign accept         = (state == IDLE) && bus.reqValid;
    assign timeout        = !bus.memAck && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_misaligned)                 state_next = RESP;
                    else if (bus.reqWrite && req_word)  state_next = WRITE;
                    else                                state_next = READ;
                end
            end
            READ: begin
                if (bus.memAck)   state_next = is_write ? WRITE : RESP;
                else if (timeout) state_next = RESP;
            end
            WRITE: begin
                if (bus.memAck || timeout) state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.reqReady = (state == IDLE);
        bus.memRead  = (state == READ);
        bus.memWrite = (state == WRITE);
        bus.rspValid = (state == RESP);
        bus.rspData  = rsp_data;
        bus.rspError = rsp_error;
        bus.memAddr  = mem_addr;
        bus.memWData = mem_wdata;
    end

    // Wait counter restarts at the start of each bus phase.
    always_ff @(posedge clk) begin
        if (!resetn)
            cnt <= 16'd0;
        else if ((state == IDLE) || ((state == READ) && bus.memAck))
            cnt <= 16'd0;
        else if (((state == READ) || (state == WRITE)) && !bus.memAck)
            cnt <= cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            off       <= 2'd0;
            len       <= 2'd0;
            is_write  <= 1'b0;
            sext      <= 1'b0;
            wdata     <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rsp_data  <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        off       <= req_off;
                        len       <= bus.reqLen;
                        is_write  <= bus.reqWrite;
                        sext      <= bus.reqSignExtend;
                        wdata     <= bus.reqWData;
                        mem_addr  <= {bus.reqAddr[31:2], 2'b00};
                        mem_wdata <= bus.reqWData;
                        if (req_misaligned) begin
                            rsp_data  <= 32'd0;
                            rsp_error <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (bus.memAck) begin
                        if (is_write) begin
                            mem_wdata <= store_merge(bus.memRData, wdata, off, len);
                        end else begin
                            rsp_data  <= load_extract(bus.memRData, off, len, sext);
                            rsp_error <= 1'b0;
                        end
                    end else if (timeout) begin
                        rsp_data  <= 32'd0;
                        rsp_error <= 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.memAck) begin
                        rsp_data  <= 32'd0;
                        rsp_error <= 1'b0;
                    end else if (timeout) begin
                        rsp_data  <= 32'd0;
                        rsp_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference model, randomized bus
// responder with wait states, and a per-cycle compare process.
module tb_mem_access_unit;
    localparam int TO    = 4;
    localparam int NEVER = 255;
    localparam logic [1:0] LB = 2'd0, LH = 2'd1, LW = 2'd2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_access_if bus_if();

    mem_access_unit #(.BUS_TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] bus_mem [16];
    logic [31:0] ref_mem [16];
    int          cur_wait = 0;

    bit          pending = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_data, exp_addr, exp_wword;
    logic        exp_err;
    int          exp_lat, exp_rd, exp_wr;
    int          acc_cyc, rd_cnt, wr_cnt;
    logic [31:0] last_data = 32'd0;
    logic        last_err = 1'b0;
    logic [31:0] got_data;
    logic        got_err;
    int          got_lat, got_rd, got_wr;

    bit resp_active = 1'b0;
    bit resp_acked = 1'b0;
    int resp_waited = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                               input int n, input bit sx);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = w[8*(off+k) +: 8];
        if (sx && n < 4 && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                                input int off, input int n);
        logic [31:0] r;
        r = w;
        for (int k = 0; k < n; k++) r[8*(off+k) +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // Bus responder: acks after cur_wait cycles per phase, noise when idle.
    initial begin
        bus_if.memAck   = 1'b0;
        bus_if.memRData = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.memRead || bus_if.memWrite) begin
                if (!resp_active || resp_acked) resp_waited = 0;
                resp_active = 1'b1;
                resp_acked  = 1'b0;
                if (cur_wait != NEVER && resp_waited == cur_wait) begin
                    bus_if.memAck = 1'b1;
                    resp_acked    = 1'b1;
                    if (bus_if.memRead) begin
                        bus_if.memRData = bus_mem[bus_if.memAddr[5:2]];
                    end else begin
                        bus_mem[bus_if.memAddr[5:2]] = bus_if.memWData;
                        bus_if.memRData = $urandom;
                    end
                end else begin
                    bus_if.memAck   = 1'b0;
                    bus_if.memRData = $urandom;
                    resp_waited++;
                end
            end else begin
                resp_active     = 1'b0;
                resp_acked      = 1'b0;
                bus_if.memAck   = 1'($urandom_range(0, 1));
                bus_if.memRData = $urandom;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("strobe_exclusive", 32'(bus_if.memRead & bus_if.memWrite), 32'd0);
            chk("req_ready", 32'(bus_if.reqReady), 32'(!pending));
            if (!pending) chk("idle_strobes", 32'({bus_if.memRead, bus_if.memWrite}), 32'd0);
            if (bus_if.memRead || bus_if.memWrite) chk("mem_addr", bus_if.memAddr, exp_addr);
            if (bus_if.memWrite) chk("mem_wdata", bus_if.memWData, exp_wword);
            if (bus_if.memRead)  rd_cnt++;
            if (bus_if.memWrite) wr_cnt++;
            if (bus_if.rspValid) begin
                if (!pending) begin
                    chk("spurious_rsp", 32'(bus_if.rspValid), 32'd0);
                end else begin
                    got_lat  = cyc - acc_cyc + 1;
                    got_data = bus_if.rspData;
                    got_err  = bus_if.rspError;
                    got_rd   = rd_cnt;
                    got_wr   = wr_cnt;
                    chk("rsp_data", got_data, exp_data);
                    chk("rsp_error", 32'(got_err), 32'(exp_err));
                    chk("rsp_latency", 32'(got_lat), 32'(exp_lat));
                    chk("read_cycles", 32'(got_rd), 32'(exp_rd));
                    chk("write_cycles", 32'(got_wr), 32'(exp_wr));
                    last_data = exp_data;
                    last_err  = exp_err;
                    pending   = 1'b0;
                end
            end else begin
                chk("rsp_data_hold", bus_if.rspData, last_data);
                chk("rsp_error_hold", 32'(bus_if.rspError), 32'(last_err));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the unit idle.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [1:0] len,
                         input bit sx, input logic [31:0] wd, input int wt, input bit abort);
        int n, off, nb;
        logic [3:0] idx;
        off = int'(addr[1:0]);
        nb  = (len == LB) ? 1 : (len == LH) ? 2 : 4;
        idx = addr[5:2];
        cur_wait  = wt;
        exp_addr  = addr & ~32'h3;
        exp_wword = 32'd0;
        exp_data  = 32'd0;
        exp_err   = 1'b0;
        exp_rd    = 0;
        exp_wr    = 0;
        if (off + nb > 4) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else if (wt == NEVER) begin
            exp_err = 1'b1;
            exp_lat = 1 + TO;
            if (wr && nb == 4) begin
                exp_wr    = TO;
                exp_wword = wd;
            end else begin
                exp_rd = TO;
            end
        end else if (!wr) begin
            exp_data = model_load(ref_mem[idx], off, nb, sx);
            exp_lat  = 2 + wt;
            exp_rd   = wt + 1;
        end else if (nb == 4) begin
            exp_wword    = wd;
            ref_mem[idx] = wd;
            exp_lat      = 2 + wt;
            exp_wr       = wt + 1;
        end else begin
            exp_wword    = model_store(ref_mem[idx], wd, off, nb);
            ref_mem[idx] = exp_wword;
            exp_lat      = 3 + 2 * wt;
            exp_rd       = wt + 1;
            exp_wr       = wt + 1;
        end

        bus_if.reqValid      = 1'b1;
        bus_if.reqWrite      = wr;
        bus_if.reqAddr       = addr;
        bus_if.reqLen        = len;
        bus_if.reqSignExtend = sx;
        bus_if.reqWData      = wd;
        n = 0;
        while (!bus_if.reqReady && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        pending = 1'b1;
        acc_cyc = cyc;
        rd_cnt  = 0;
        wr_cnt  = 0;
        bus_if.reqValid      = 1'b0;
        bus_if.reqWrite      = 1'($urandom_range(0, 1));
        bus_if.reqAddr       = $urandom;
        bus_if.reqLen        = 2'($urandom_range(0, 3));
        bus_if.reqSignExtend = 1'($urandom_range(0, 1));
        bus_if.reqWData      = $urandom;

        if (abort) begin
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            resetn = 1'b0;
            @(posedge clk);
            #1;
            resetn    = 1'b1;
            pending   = 1'b0;
            last_data = 32'd0;
            last_err  = 1'b0;
            return;
        end

        n = 0;
        while (pending && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pending) begin
            chk("rsp_arrived", 32'(pending), 32'd0);
            pending = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.reqValid      = 1'b0;
        bus_if.reqWrite      = 1'b0;
        bus_if.reqAddr       = 32'd0;
        bus_if.reqLen        = 2'd0;
        bus_if.reqSignExtend = 1'b0;
        bus_if.reqWData      = 32'd0;
        for (int i = 0; i < 16; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("reset_req_ready", 32'(bus_if.reqReady), 32'd1);
        chk("reset_strobes", 32'({bus_if.memRead, bus_if.memWrite}), 32'd0);
        chk("reset_rsp_valid", 32'(bus_if.rspValid), 32'd0);
        chk("reset_rsp_error", 32'(bus_if.rspError), 32'd0);
        chk("reset_rsp_data", bus_if.rspData, 32'd0);
        chk("reset_mem_addr", bus_if.memAddr, 32'd0);
        chk("reset_mem_wdata", bus_if.memWData, 32'd0);
        resetn = 1'b1;

        bus_mem[0] = 32'h80FF_1234;
        ref_mem[0] = 32'h80FF_1234;
        issue(1'b0, 32'h0000_1003, LB, 1'b1, $urandom, 0, 1'b0);
        chk("tp_lb_sext_data", got_data, 32'hFFFF_FF80);
        chk("tp_lb_latency", 32'(got_lat), 32'd2);
        chk("tp_lb_mem_addr", bus_if.memAddr, 32'h0000_1000);
        issue(1'b0, 32'h0000_1003, LB, 1'b0, $urandom, 0, 1'b0);
        chk("tp_lb_zext_data", got_data, 32'h0000_0080);

        bus_mem[0] = 32'h1122_3344;
        ref_mem[0] = 32'h1122_3344;
        issue(1'b1, 32'h0000_2001, LH, 1'b0, 32'hAAAA_BEEF, 0, 1'b0);
        chk("tp_sh_memory", bus_mem[0], 32'h11BE_EF44);
        chk("tp_sh_latency", 32'(got_lat), 32'd3);
        chk("tp_sh_error", 32'(got_err), 32'd0);
        chk("tp_sh_mem_addr", bus_if.memAddr, 32'h0000_2000);

        issue(1'b1, 32'h0000_3000, LW, 1'b0, 32'hDEAD_BEEF, 2, 1'b0);
        chk("tp_sw_latency", 32'(got_lat), 32'd4);
        chk("tp_sw_write_cycles", 32'(got_wr), 32'd3);
        chk("tp_sw_read_cycles", 32'(got_rd), 32'd0);
        chk("tp_sw_memory", bus_mem[0], 32'hDEAD_BEEF);

        issue(1'b0, 32'h0000_4002, LW, 1'b0, $urandom, 0, 1'b0);
        chk("tp_mis_w_latency", 32'(got_lat), 32'd1);
        chk("tp_mis_w_error", 32'(got_err), 32'd1);
        chk("tp_mis_w_data", got_data, 32'd0);
        issue(1'b0, 32'h0000_4003, LH, 1'b1, $urandom, 0, 1'b0);
        chk("tp_mis_h_latency", 32'(got_lat), 32'd1);
        chk("tp_mis_h_error", 32'(got_err), 32'd1);
        chk("tp_mis_h_strobes", 32'(got_rd + got_wr), 32'd0);

        issue(1'b1, 32'h0000_5001, LB, 1'b0, $urandom, NEVER, 1'b0);
        chk("tp_to_read_cycles", 32'(got_rd), 32'd4);
        chk("tp_to_write_cycles", 32'(got_wr), 32'd0);
        chk("tp_to_error", 32'(got_err), 32'd1);

        bus_mem[1] = 32'hCAFE_F00D;
        ref_mem[1] = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_6004, LW, 1'b0, $urandom, NEVER, 1'b1);
        chk("tp_rst_strobes", 32'({bus_if.memRead, bus_if.memWrite}), 32'd0);
        issue(1'b0, 32'h0000_6004, LW, 1'b0, $urandom, 1, 1'b0);
        chk("tp_rst_reload_data", got_data, 32'hCAFE_F00D);
        chk("tp_rst_reload_latency", 32'(got_lat), 32'd3);

        for (int t = 0; t < 250; t++) begin
            int wt;
            wt = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, wt, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 16; i++) chk("final_memory", bus_mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
